prog_mem_loader: RTL and testbench

Program/data memory for the 8-bit CPU, sitting directly downstream of the CPU datapath. It consumes the CPU's address, data-out, read and write strobes, and drives the CPU's data input. It also contains a switch-driven loader FSM so a program can be keyed in and read back before running, using the same cpustate selector as the clock-gating logic.

---
 rtl/prog_mem_loader.sv | 212 +++++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
// rtl/prog_mem_loader.sv - CPU program/data memory with switch-driven loader
//
// Purpose:
//   Byte-wide memory for the 8-bit CPU. In RUN mode the CPU reads and writes it.
//   In LOAD mode a program is keyed in from switches, one byte per step press.
//   In CHECK mode the loaded bytes are read back, one byte per step press.
//
// Optional build macro:
//   MEM_CLEAR_EN - after reset, sweep every location to zero with busy=1.
//
// Ports:
//   clk        system clock, shared with the CPU registers
//   rst        asynchronous active-high reset
//   cpustate   mode select: 00 IDLE, 01 LOAD, 10 CHECK, 11 RUN
//   addr       CPU address; bits above ADDR_W must be zero in RUN
//   data_out   CPU write data
//   read       CPU read strobe
//   write      CPU write strobe
//   sw_data    switch byte stored on a LOAD step
//   sw_step    step button, level, asynchronous to clk
//   data_in    CPU read data (RUN) or readback byte (CHECK), else 0
//   load_addr  loader pointer
//   load_done  sticky: pointer wrapped during LOAD/CHECK
//   err_oob    sticky: RUN access with out-of-range address
//   busy       clear sweep in progress (0 unless MEM_CLEAR_EN)

module prog_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cpustate,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] data_out,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              sw_step,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] load_addr,
  output logic              load_done,
  output logic              err_oob,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    M_IDLE  = 2'b00,
    M_LOAD  = 2'b01,
    M_CHECK = 2'b10,
    M_RUN   = 2'b11
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [ADDR_W-1:0] load_addr_q, load_addr_d;
  logic              load_done_q, load_done_d;
  logic              err_oob_q, err_oob_d;
  logic [2:0]        step_sync_q, step_sync_d;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              step_pulse;
  logic              cpu_oob;
  logic [ADDR_W-1:0] cpu_idx;
  logic              entering_loader;
  logic              clr_busy;
  logic [ADDR_W-1:0] clr_waddr;

  // [0],[1] form the synchroniser; [2] is the delayed copy for edge detect,
  // so a held button yields a single pulse.
  assign step_sync_d = {step_sync_q[1:0], sw_step};
  assign step_pulse  = step_sync_q[1] & ~step_sync_q[2] & ~clr_busy;

  assign cpu_idx = addr[ADDR_W-1:0];
  assign cpu_oob = |(addr >> ADDR_W);

  // Pointer restarts whenever the selector newly enters LOAD or CHECK.
  assign entering_loader = (mode_e'(cpustate) != mode_q) &&
                           ((mode_e'(cpustate) == M_LOAD) || (mode_e'(cpustate) == M_CHECK));

`ifdef MEM_CLEAR_EN
  typedef enum logic [1:0] {
    CLR_ARMED = 2'b00,
    CLR_SWEEP = 2'b01,
    CLR_DONE  = 2'b10
  } clr_e;

  clr_e              clr_q, clr_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  // ARMED holds through reset so the sweep starts on the first edge after
  // release and spends exactly DEPTH cycles in SWEEP.
  always_comb begin
    clr_d      = clr_q;
    clr_addr_d = clr_addr_q;
    case (clr_q)
      CLR_ARMED: begin
        clr_d      = CLR_SWEEP;
        clr_addr_d = '0;
      end
      CLR_SWEEP: begin
        clr_addr_d = clr_addr_q + 1'b1;
        if (&clr_addr_q) clr_d = CLR_DONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_q      <= CLR_ARMED;
      clr_addr_q <= '0;
    end else begin
      clr_q      <= clr_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign clr_busy  = (clr_q == CLR_SWEEP);
  assign clr_waddr = clr_addr_q;
`else
  assign clr_busy  = 1'b0;
  assign clr_waddr = '0;
`endif

  assign busy = clr_busy;

  always_comb begin
    mode_d      = mode_e'(cpustate);
    load_addr_d = load_addr_q;
    load_done_d = load_done_q;
    err_oob_d   = err_oob_q;

    if (((mode_q == M_LOAD) || (mode_q == M_CHECK)) && step_pulse) begin
      load_addr_d = load_addr_q + 1'b1;
      if (&load_addr_q) load_done_d = 1'b1;
    end

    if ((mode_q == M_RUN) && !clr_busy && (read || write) && cpu_oob) begin
      err_oob_d = 1'b1;
    end

    if (entering_loader) begin
      load_addr_d = '0;
      load_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= M_IDLE;
      load_addr_q <= '0;
      load_done_q <= 1'b0;
      err_oob_q   <= 1'b0;
      step_sync_q <= '0;
    end else begin
      mode_q      <= mode_d;
      load_addr_q <= load_addr_d;
      load_done_q <= load_done_d;
      err_oob_q   <= err_oob_d;
      step_sync_q <= step_sync_d;
    end
  end

  // Single write port shared by the clear sweep, the loader and the CPU.
  // rst gates the enable so a write on the edge where reset rises is dropped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cpu_idx;
    mem_wdata = data_out;
    if (clr_busy) begin
      mem_we    = 1'b1;
      mem_waddr = clr_waddr;
      mem_wdata = '0;
    end else if ((mode_q == M_LOAD) && step_pulse) begin
      mem_we    = 1'b1;
      mem_waddr = load_addr_q;
      mem_wdata = sw_data;
    end else if ((mode_q == M_RUN) && write && !cpu_oob) begin
      mem_we    = 1'b1;
    end
    if (rst) mem_we = 1'b0;
  end

  // Contents are retained across reset, so no reset branch here.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Combinational read: the CPU samples data_in in the same cycle as read,
  // and a simultaneous write shows the pre-write byte.
  always_comb begin
    data_in = '0;
    if (!clr_busy) begin
      case (mode_q)
        M_CHECK: data_in = mem_q[load_addr_q];
        M_RUN:   if (read && !cpu_oob) data_in = mem_q[cpu_idx];
        default: ;
      endcase
    end
  end

  assign load_addr = load_addr_q;
  assign load_done = load_done_q;
  assign err_oob   = err_oob_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb/tb_prog_mem_loader.sv - self-checking bench for prog_mem_loader

module tb_prog_mem_loader;

  logic        clk;
  logic        rst;
  logic [1:0]  cpustate;
  logic [15:0] addr;
  logic [7:0]  data_out;
  logic        read;
  logic        write;
  logic [7:0]  sw_data;
  logic        sw_step;
  logic [7:0]  data_in;
  logic [7:0]  load_addr;
  logic        load_done;
  logic        err_oob;
  logic        busy;

  int checks;
  int failures;

  prog_mem_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpustate  (cpustate),
    .addr      (addr),
    .data_out  (data_out),
    .read      (read),
    .write     (write),
    .sw_data   (sw_data),
    .sw_step   (sw_step),
    .data_in   (data_in),
    .load_addr (load_addr),
    .load_done (load_done),
    .err_oob   (err_oob),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic [7:0]  exp_din;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input int hold);
    sw_step = 1'b1;
    repeat (hold) @(negedge clk);
    sw_step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Counts busy cycles after reset release; only meaningful with the clear sweep.
  task automatic wait_clear();
    int cnt;
    cnt = 0;
    for (int g = 0; g < 600; g++) begin
      @(negedge clk);
      if (busy) cnt++;
      else if (cnt > 0) break;
    end
    check("clear_cycles", cnt, 256);
  endtask

  logic [7:0] mem0_exp;

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    cpustate = 2'b00;
    addr     = 16'h0;
    data_out = 8'h0;
    read     = 1'b0;
    write    = 1'b0;
    sw_data  = 8'h0;
    sw_step  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_load_addr", int'(load_addr), 0);
    check("rst_load_done", int'(load_done), 0);
    check("rst_err_oob",   int'(err_oob), 0);
    check("rst_data_in",   int'(data_in), 0);
    check("rst_busy",      int'(busy), 0);
    rst = 1'b0;
`ifdef MEM_CLEAR_EN
    wait_clear();
`endif

    // LOAD: step latency and single pulse on a held button
    cpustate = 2'b01;
    @(negedge clk);
    sw_data = 8'hA5;
    sw_step = 1'b1;
    @(negedge clk);
    check("lat_edge1", int'(load_addr), 0);
    @(negedge clk);
    check("lat_edge2", int'(load_addr), 0);
    @(negedge clk);
    check("lat_edge3", int'(load_addr), 1);
    repeat (3) @(negedge clk);
    check("hold_one_pulse", int'(load_addr), 1);
    sw_step = 1'b0;
    repeat (4) @(negedge clk);
    sw_data = 8'h3C;
    press(6);
    check("load_addr_2", int'(load_addr), 2);

    // CHECK readback
    cpustate = 2'b10;
    @(negedge clk);
    check("chk_ptr_reset", int'(load_addr), 0);
    check("chk_byte0", int'(data_in), 8'hA5);
    press(1);
    check("chk_ptr_1", int'(load_addr), 1);
    check("chk_byte1", int'(data_in), 8'h3C);

    // RUN table: data_in is combinational, err_oob reflects earlier edges
    vecs[0] = '{16'h0001, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0};
    vecs[1] = '{16'h0000, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b0};
    vecs[2] = '{16'h0001, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[3] = '{16'h0001, 1'b0, 1'b1, 8'h77, 8'h00, 1'b0};
    vecs[4] = '{16'h0001, 1'b1, 1'b0, 8'h00, 8'h77, 1'b0};
    vecs[5] = '{16'h0001, 1'b1, 1'b1, 8'h99, 8'h77, 1'b0};
    vecs[6] = '{16'h0001, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0};
    vecs[7] = '{16'h0100, 1'b0, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[8] = '{16'h0000, 1'b1, 1'b0, 8'h00, 8'hA5, 1'b1};
    vecs[9] = '{16'h8001, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
    cpustate = 2'b11;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      addr     = vecs[i].a;
      read     = vecs[i].rd;
      write    = vecs[i].wr;
      data_out = vecs[i].dout;
      #1;
      check($sformatf("run_vec%0d_din", i), int'(data_in), int'(vecs[i].exp_din));
      check($sformatf("run_vec%0d_err", i), int'(err_oob), int'(vecs[i].exp_err));
      @(negedge clk);
    end
    write = 1'b0;
    read  = 1'b0;

    // IDLE: no readout, steps ignored, err_oob still held
    cpustate = 2'b00;
    @(negedge clk);
    addr = 16'h0001;
    read = 1'b1;
    #1;
    check("idle_data_in", int'(data_in), 0);
    check("idle_err_sticky", int'(err_oob), 1);
    read = 1'b0;
    press(2);
    check("idle_step_ignored", int'(load_addr), 1);

    // Reset mid-operation
    rst = 1'b1;
    #1;
    check("mid_rst_ptr", int'(load_addr), 0);
    check("mid_rst_err", int'(err_oob), 0);
    @(negedge clk);
    rst = 1'b0;
`ifdef MEM_CLEAR_EN
    wait_clear();
    mem0_exp = 8'h00;
`else
    mem0_exp = 8'hA5;
`endif
    cpustate = 2'b10;
    @(negedge clk);
    check("retain_mem0", int'(data_in), int'(mem0_exp));

    // Step pending across LOAD->CHECK: pulse lands in CHECK, so no write
    cpustate = 2'b01;
    @(negedge clk);
    sw_data = 8'hEE;
    sw_step = 1'b1;
    @(negedge clk);
    cpustate = 2'b10;
    @(negedge clk);
    check("pend_ptr_reset", int'(load_addr), 0);
    @(negedge clk);
    check("pend_ptr_step", int'(load_addr), 1);
    sw_step = 1'b0;
    repeat (4) @(negedge clk);
    cpustate = 2'b11;
    @(negedge clk);
    addr = 16'h0000;
    read = 1'b1;
    #1;
    check("pend_no_write", int'(data_in), int'(mem0_exp));
    read = 1'b0;

    // Full wrap in LOAD
    cpustate = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      sw_data = 8'(i) ^ 8'h5A;
      press(1);
      if (i == 254) begin
        check("wrap_ptr_255", int'(load_addr), 255);
        check("wrap_done_pre", int'(load_done), 0);
      end
    end
    check("wrap_ptr_0", int'(load_addr), 0);
    check("wrap_done", int'(load_done), 1);
    cpustate = 2'b10;
    @(negedge clk);
    check("chk_done_clear", int'(load_done), 0);
    check("wrap_byte0", int'(data_in), 8'h5A);
    cpustate = 2'b11;
    @(negedge clk);
    addr = 16'h00FF;
    read = 1'b1;
    #1;
    check("wrap_byte255", int'(data_in), 8'hA5);
    addr = 16'h0010;
    #1;
    check("wrap_byte16", int'(data_in), 8'h4A);
    read = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
